cypher_stream_tx: RTL and testbench

Stream transmitter feeding the cypher detector's control interface. Buffers cipher symbols written by the host in a small FIFO, then on a `send` request frames them as a burst: `read` on the first symbol, one symbol per clock, `stop` one cycle after the last. It drives the `read`/`stop` inputs and the symbol data path that the detector's control FSM consumes.

---
 rtl/cypher_pkg.sv | 22 ++
 rtl/cypher_tx_fifo.sv | 59 +++++
 rtl/cypher_stream_tx.sv | 150 +++++++++++++++
 tb/tb_cypher_stream_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cypher_pkg.sv
// Shared types for the cypher transmitter and detector: burst FSM states, default symbol width
// and the detector-side control FSM encodings.
package cypher_pkg;

    localparam int unsigned CypherDataW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StStop,
        StDone
    } tx_state_t;

    // Detector control FSM encodings; the detector decodes these from the read/stop stream.
    typedef enum logic [1:0] {
        DetIdle    = 2'd0,
        DetRead    = 2'd1,
        DetCompare = 2'd2,
        DetStop    = 2'd3
    } det_state_t;

endpackage

// File: rtl/cypher_tx_fifo.sv
// Synchronous FIFO with occupancy count; full/empty are derived from the level, not the pointers.
module cypher_tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q;
    logic              push_ok, pop_ok;

    assign full    = (level_q == LvlFull);
    assign empty   = (level_q == '0);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                level_q <= level_q + (AW + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                level_q <= level_q - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/cypher_stream_tx.sv
// Burst transmitter: buffers host symbols and frames them as read/symbols/stop/done bursts.
// Optional sym_parity output is enabled by defining CYPHER_TX_PARITY_EN.
module cypher_stream_tx
    import cypher_pkg::*;
#(
    parameter int unsigned DATA_W = CypherDataW,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    input  logic                   send,
    output logic                   busy,
    output logic                   done,
    output logic                   read,
    output logic                   stop,
    output logic                   sym_valid,
    output logic [DATA_W-1:0]      sym_data,
    output logic [$clog2(DEPTH):0] level
`ifdef CYPHER_TX_PARITY_EN
    ,
    output logic                   sym_parity
`endif
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    tx_state_t         state_q, state_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic              pop, full, empty;
    logic [DATA_W-1:0] head;
    logic              read_q, read_d, stop_q, stop_d, done_q, done_d;
    logic              sym_valid_q, sym_valid_d;
    logic [DATA_W-1:0] sym_data_q, sym_data_d;

    // Assert asynchronously, release on the clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    assign wr_ready = ~full | pop;

    cypher_tx_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset_n(rst_n),
        .push   (wr_valid & wr_ready),
        .pop    (pop),
        .wdata  (wr_data),
        .rdata  (head),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    // The head is popped on the edge that loads it into the output register, so the first
    // symbol appears the cycle after send.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        read_d      = 1'b0;
        stop_d      = 1'b0;
        done_d      = 1'b0;
        sym_valid_d = 1'b0;
        sym_data_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (send && !empty) begin
                    state_d     = StStream;
                    cnt_d       = level - LW'(1);
                    pop         = 1'b1;
                    read_d      = 1'b1;
                    sym_valid_d = 1'b1;
                    sym_data_d  = head;
                end
            end
            StStream: begin
                if (cnt_q != '0) begin
                    cnt_d       = cnt_q - LW'(1);
                    pop         = 1'b1;
                    sym_valid_d = 1'b1;
                    sym_data_d  = head;
                end else begin
                    state_d = StStop;
                    stop_d  = 1'b1;
                end
            end
            StStop: begin
                state_d = StDone;
                done_d  = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            read_q      <= 1'b0;
            stop_q      <= 1'b0;
            done_q      <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_q      <= read_d;
            stop_q      <= stop_d;
            done_q      <= done_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign read      = read_q;
    assign stop      = stop_q;
    assign done      = done_q;
    assign sym_valid = sym_valid_q;
    assign sym_data  = sym_data_q;

`ifdef CYPHER_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^sym_data_d;
        end
    end
    assign sym_parity = parity_q;
`endif

endmodule

// File: tb/tb_cypher_stream_tx.sv
// Scoreboard bench for cypher_stream_tx: queue-based FIFO model, randomized bursts.
module tb_cypher_stream_tx;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       send = 1'b0;
    logic       wr_ready, busy, done, read, stop, sym_valid;
    logic [7:0] sym_data;
    logic [4:0] level;
`ifdef CYPHER_TX_PARITY_EN
    logic       sym_parity;
`endif

    typedef struct {
        logic [7:0] data;
        bit         first;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    int         tests = 0;
    int         fails = 0;

    always #5 clock = ~clock;

    cypher_stream_tx #(
        .DATA_W(8),
        .DEPTH (DEPTH)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .send     (send),
        .busy     (busy),
        .done     (done),
        .read     (read),
        .stop     (stop),
        .sym_valid(sym_valid),
        .sym_data (sym_data),
        .level    (level)
`ifdef CYPHER_TX_PARITY_EN
        ,
        .sym_parity(sym_parity)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every presented symbol must be the next one the model expects.
    initial begin
        forever begin
            @(negedge clock);
            if (sym_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_symbol: got 0x%0h, want none at %0t", sym_data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sym_data", sym_data, e.data);
                    check("read_flag", read, e.first);
`ifdef CYPHER_TX_PARITY_EN
                    check("sym_parity", sym_parity, $countones(e.data) % 2);
`endif
                end
            end else begin
                check("idle_sym_data", sym_data, 0);
                check("idle_read", read, 0);
`ifdef CYPHER_TX_PARITY_EN
                check("idle_parity", sym_parity, 0);
`endif
            end
        end
    end

    task automatic wr(input logic [7:0] d);
        bit room;
        @(negedge clock);
        room = (model_q.size() < DEPTH);
        wr_valid = 1'b1;
        wr_data  = d;
        check("wr_ready", wr_ready, room);
        if (room) model_q.push_back(d);
        @(negedge clock);
        wr_valid = 1'b0;
        check("level_after_wr", level, model_q.size());
    endtask

    // Pulses send and checks framing; optionally writes mid_data during the first STREAM cycle.
    task automatic do_send(input bit mid_wr, input logic [7:0] mid_data);
        int n;
        @(negedge clock);
        send = 1'b1;
        n = model_q.size();
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data  = model_q[i];
            e.first = (i == 0);
            exp_q.push_back(e);
        end
        model_q.delete();
        @(negedge clock);
        send = 1'b0;
        if (n == 0) begin
            repeat (4) begin
                check("empty_busy", busy, 0);
                check("empty_read", read, 0);
                check("empty_stop", stop, 0);
                check("empty_done", done, 0);
                @(negedge clock);
            end
            return;
        end
        for (int i = 0; i < n; i++) begin
            check("stream_busy", busy, 1);
            check("stream_valid", sym_valid, 1);
            check("stream_stop", stop, 0);
            if (mid_wr && i == 0) begin
                wr_valid = 1'b1;
                wr_data  = mid_data;
                check("mid_wr_ready", wr_ready, 1);
                model_q.push_back(mid_data);
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clock);
        end
        wr_valid = 1'b0;
        check("stop_pulse", stop, 1);
        check("stop_valid", sym_valid, 0);
        check("stop_done", done, 0);
        @(negedge clock);
        check("done_pulse", done, 1);
        check("done_stop", stop, 0);
        check("done_busy", busy, 1);
        @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("level_after_burst", level, model_q.size());
        check("burst_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", read, 0);
        check("rst_stop", stop, 0);
        check("rst_valid", sym_valid, 0);
        check("rst_data", sym_data, 0);
        check("rst_level", level, 0);
        check("rst_wr_ready", wr_ready, 1);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        wr(8'h41); wr(8'h42); wr(8'h43);
        do_send(1'b0, 8'h00);
        do_send(1'b0, 8'h00);

        // Two full bursts; the 17th write each time must be refused.
        repeat (2) begin
            repeat (DEPTH + 1) wr(8'($urandom));
            do_send(1'b0, 8'h00);
        end

        wr(8'hA0); wr(8'hA1);
        do_send(1'b1, 8'h55);
        do_send(1'b0, 8'h00);

        repeat (6) begin
            n = $urandom_range(1, DEPTH);
            repeat (n) wr(8'($urandom));
            do_send((n >= 2) && ($urandom_range(0, 1) == 1), 8'($urandom));
        end
        do_send(1'b0, 8'h00);

        wr(8'h07); wr(8'h03);
        do_send(1'b0, 8'h00);

        // Reset during the second symbol of a 4-symbol burst.
        repeat (4) wr(8'($urandom));
        @(negedge clock);
        send = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.data  = model_q[i];
            e.first = (i == 0);
            exp_q.push_back(e);
        end
        model_q.delete();
        @(negedge clock);
        send = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort_valid", sym_valid, 0);
        check("abort_data", sym_data, 0);
        check("abort_read", read, 0);
        check("abort_stop", stop, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_level", level, 0);
        check("abort_wr_ready", wr_ready, 1);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) begin
            check("post_abort_stop", stop, 0);
            check("post_abort_done", done, 0);
            check("post_abort_busy", busy, 0);
            @(negedge clock);
        end
        check("post_abort_level", level, 0);
        wr(8'h99);
        do_send(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        tests++;
        fails++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
